// File: rtl/rtc_time_core_if.sv
// Bus between the time-of-day core and its controller/display side.
// Control, set, alarm and display-mode inputs plus time and strobe outputs.
interface rtc_time_core_if;
    logic       run;
    logic       load;
    logic [5:0] set_hour;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       alarm_en;
    logic [5:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       mode12;
    logic [5:0] sec;
    logic [5:0] min;
    logic [5:0] hour;
    logic [5:0] disp_hour;
    logic       pm;
    logic       sec_tick;
    logic       day_tick;
    logic       alarm;
    logic       load_err;

    modport master (
        output run, load, set_hour, set_min, set_sec,
        output alarm_en, alarm_hour, alarm_min, mode12,
        input  sec, min, hour, disp_hour, pm,
        input  sec_tick, day_tick, alarm, load_err
    );

    modport slave (
        input  run, load, set_hour, set_min, set_sec,
        input  alarm_en, alarm_hour, alarm_min, mode12,
        output sec, min, hour, disp_hour, pm,
        output sec_tick, day_tick, alarm, load_err
    );
endinterface

// File: rtl/rtc_time_core.sv
// hh:mm:ss time-of-day counter with seconds prescaler, validated load,
// alarm match, day-rollover strobe and 12/24-hour display conversion.
module rtc_time_core #(
    parameter int CLK_DIV = 50_000_000,
    parameter int HOURS   = 24
) (
    input logic          clock,
    input logic          reset,
    rtc_time_core_if.slave bus
);
    localparam int              PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]   PRE_MAX  = PW'(CLK_DIV - 1);
    localparam logic [5:0]      HOUR_MAX = 6'(HOURS - 1);
    localparam logic [6:0]      HOUR_LIM = 7'(HOURS);

    logic [PW-1:0] pre_q, pre_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    hour_q, hour_d;
    logic          sec_tick_q, sec_tick_d;
    logic          day_tick_q, day_tick_d;
    logic          alarm_q, alarm_d;
    logic          load_err_q, load_err_d;

    logic          tick;
    logic          load_ok;
    logic [5:0]    nsec, nmin, nhour;
    logic          wrap_day;
    logic [5:0]    disp;

    assign tick    = bus.run && (pre_q == PRE_MAX);
    assign load_ok = (bus.set_sec <= 6'd59) && (bus.set_min <= 6'd59) &&
                     ({1'b0, bus.set_hour} < HOUR_LIM);

    // Time one second ahead of the current registers, with carries.
    always_comb begin
        nsec     = sec_q + 6'd1;
        nmin     = min_q;
        nhour    = hour_q;
        wrap_day = 1'b0;
        if (sec_q == 6'd59) begin
            nsec = 6'd0;
            if (min_q == 6'd59) begin
                nmin = 6'd0;
                if (hour_q == HOUR_MAX) begin
                    nhour    = 6'd0;
                    wrap_day = 1'b1;
                end else begin
                    nhour = hour_q + 6'd1;
                end
            end else begin
                nmin = min_q + 6'd1;
            end
        end
    end

    // Next state: load beats a coincident tick, otherwise prescale and advance.
    always_comb begin
        pre_d      = pre_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        sec_tick_d = 1'b0;
        day_tick_d = 1'b0;
        alarm_d    = 1'b0;
        load_err_d = 1'b0;
        if (bus.load) begin
            if (load_ok) begin
                sec_d  = bus.set_sec;
                min_d  = bus.set_min;
                hour_d = bus.set_hour;
                pre_d  = '0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.run) begin
            if (tick) begin
                pre_d      = '0;
                sec_d      = nsec;
                min_d      = nmin;
                hour_d     = nhour;
                sec_tick_d = 1'b1;
                day_tick_d = wrap_day;
                alarm_d    = bus.alarm_en && (nsec == 6'd0) &&
                             (nmin == bus.alarm_min) &&
                             (nhour == bus.alarm_hour);
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    // State and strobe registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_q      <= '0;
            sec_q      <= 6'd0;
            min_q      <= 6'd0;
            hour_q     <= 6'd0;
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
            alarm_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            sec_tick_q <= sec_tick_d;
            day_tick_q <= day_tick_d;
            alarm_q    <= alarm_d;
            load_err_q <= load_err_d;
        end
    end

    // Display hour: 12-hour form maps 0 to 12 and 13.. down by 12.
    always_comb begin
        disp = hour_q;
        if (bus.mode12) begin
            if (hour_q == 6'd0) begin
                disp = 6'd12;
            end else if (hour_q > 6'd12) begin
                disp = hour_q - 6'd12;
            end
        end
    end

    assign bus.sec       = sec_q;
    assign bus.min       = min_q;
    assign bus.hour      = hour_q;
    assign bus.disp_hour = disp;
    assign bus.pm        = (hour_q >= 6'd12);
    assign bus.sec_tick  = sec_tick_q;
    assign bus.day_tick  = day_tick_q;
    assign bus.alarm     = alarm_q;
    assign bus.load_err  = load_err_q;
endmodule

// File: tb/tb_rtc_time_core.sv
// Bench for rtc_time_core: seconds-of-day reference model, directed
// scenarios and a randomized run/load/alarm/display sequence.
module tb_rtc_time_core;
    localparam int CLK_DIV = 4;
    localparam int HOURS   = 24;
    localparam int DAY     = HOURS * 3600;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total  = 0;

    rtc_time_core_if bus ();

    rtc_time_core #(.CLK_DIV(CLK_DIV), .HOURS(HOURS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Reference model: time as seconds of the day plus a phase counter.
    int m_tod;
    int m_pre;
    bit m_sec_tick, m_day_tick, m_alarm, m_err;

    task automatic model_reset();
        m_tod = 0; m_pre = 0;
        m_sec_tick = 0; m_day_tick = 0; m_alarm = 0; m_err = 0;
    endtask

    task automatic model_step();
        int h, mi, s, ah, am;
        h  = int'(bus.set_hour);
        mi = int'(bus.set_min);
        s  = int'(bus.set_sec);
        ah = int'(bus.alarm_hour);
        am = int'(bus.alarm_min);
        m_sec_tick = 0; m_day_tick = 0; m_alarm = 0; m_err = 0;
        if (bus.load) begin
            if (s < 60 && mi < 60 && h < HOURS) begin
                m_tod = h * 3600 + mi * 60 + s;
                m_pre = 0;
            end else begin
                m_err = 1;
            end
        end else if (bus.run) begin
            if (m_pre == CLK_DIV - 1) begin
                m_pre = 0;
                m_sec_tick = 1;
                if (m_tod == DAY - 1) m_day_tick = 1;
                m_tod = (m_tod + 1) % DAY;
                if (bus.alarm_en && ah < HOURS && am < 60 &&
                    m_tod == ah * 3600 + am * 60)
                    m_alarm = 1;
            end else begin
                m_pre++;
            end
        end
    endtask

    function automatic logic [28:0] exp_vec();
        int h, mi, s, d;
        h  = m_tod / 3600;
        mi = (m_tod / 60) % 60;
        s  = m_tod % 60;
        d  = h;
        if (bus.mode12) d = (h % 12 == 0) ? 12 : h % 12;
        return {6'(s), 6'(mi), 6'(h), 6'(d), (h >= 12),
                m_sec_tick, m_day_tick, m_alarm, m_err};
    endfunction

    function automatic logic [28:0] obs_vec();
        return {bus.sec, bus.min, bus.hour, bus.disp_hour, bus.pm,
                bus.sec_tick, bus.day_tick, bus.alarm, bus.load_err};
    endfunction

    task automatic cyc();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_time(input int h, input int mi, input int s);
        bus.set_hour = 6'(h);
        bus.set_min  = 6'(mi);
        bus.set_sec  = 6'(s);
        bus.load     = 1'b1;
        cyc();
        bus.load     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        #2;
        total++;
        if (obs_vec() !== exp_vec())
            $display("FAIL reset_state got %h want %h", obs_vec(), exp_vec());
        else passed++;
        total++;
        if (obs_vec() !== 29'd0)
            $display("FAIL reset_zero got %h want 0", obs_vec());
        else passed++;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_first_second();
        bus.run = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            total++;
            if (obs_vec() !== exp_vec())
                $display("FAIL first_sec c%0d got %h want %h", i, obs_vec(), exp_vec());
            else passed++;
            if (i == 4 || i == 8) begin
                total++;
                if (bus.sec !== 6'(i / 4) || bus.sec_tick !== 1'b1)
                    $display("FAIL first_sec_edge c%0d got sec=%0d tick=%b want sec=%0d tick=1",
                             i, bus.sec, bus.sec_tick, i / 4);
                else passed++;
            end
        end
    endtask

    task automatic test_day_rollover();
        int days = 0;
        bus.run = 1'b1;
        set_time(23, 59, 58);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            if (bus.day_tick) days++;
            total++;
            if (obs_vec() !== exp_vec())
                $display("FAIL rollover c%0d got %h want %h", i, obs_vec(), exp_vec());
            else passed++;
        end
        total++;
        if (days != 1 || bus.hour !== 6'd0 || bus.sec !== 6'd0)
            $display("FAIL rollover_count got %0d ticks h=%0d want 1 tick h=0", days, bus.hour);
        else passed++;
    endtask

    task automatic test_load_err();
        bus.run = 1'b1;
        set_time(10, 0, 0);
        set_time(10, 0, 60);
        total++;
        if (obs_vec() !== exp_vec() || bus.load_err !== 1'b1)
            $display("FAIL load_err got %h want %h", obs_vec(), exp_vec());
        else passed++;
        set_time(24, 0, 0);
        total++;
        if (obs_vec() !== exp_vec())
            $display("FAIL load_err_hour got %h want %h", obs_vec(), exp_vec());
        else passed++;
        cyc();
        total++;
        if (bus.load_err !== 1'b0 || obs_vec() !== exp_vec())
            $display("FAIL load_err_pulse got %h want %h", obs_vec(), exp_vec());
        else passed++;
    endtask

    task automatic test_alarm();
        int n = 0;
        bus.run        = 1'b1;
        bus.alarm_en   = 1'b1;
        bus.alarm_hour = 6'd7;
        bus.alarm_min  = 6'd30;
        set_time(7, 29, 59);
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (bus.alarm) n++;
            total++;
            if (obs_vec() !== exp_vec())
                $display("FAIL alarm c%0d got %h want %h", i, obs_vec(), exp_vec());
            else passed++;
        end
        total++;
        if (n != 1)
            $display("FAIL alarm_count got %0d want 1", n);
        else passed++;
        n = 0;
        set_time(7, 30, 0);
        if (bus.alarm) n++;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (bus.alarm) n++;
        end
        total++;
        if (n != 0)
            $display("FAIL alarm_on_load got %0d want 0", n);
        else passed++;
        bus.alarm_en = 1'b0;
    endtask

    task automatic test_hold();
        bus.run = 1'b1;
        set_time(5, 6, 7);
        cyc();
        cyc();
        bus.run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            total++;
            if (obs_vec() !== exp_vec())
                $display("FAIL hold c%0d got %h want %h", i, obs_vec(), exp_vec());
            else passed++;
        end
        bus.run = 1'b1;
        cyc();
        total++;
        if (bus.sec !== 6'd7 || bus.sec_tick !== 1'b0)
            $display("FAIL hold_resume1 got sec=%0d tick=%b want sec=7 tick=0",
                     bus.sec, bus.sec_tick);
        else passed++;
        cyc();
        total++;
        if (bus.sec !== 6'd8 || bus.sec_tick !== 1'b1 || obs_vec() !== exp_vec())
            $display("FAIL hold_resume2 got sec=%0d tick=%b want sec=8 tick=1",
                     bus.sec, bus.sec_tick);
        else passed++;
    endtask

    task automatic test_mode12();
        int hrs [4]  = '{0, 12, 13, 23};
        int disp [4] = '{12, 12, 1, 11};
        bit pmv [4]  = '{0, 1, 1, 1};
        bus.run    = 1'b0;
        bus.mode12 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_time(hrs[i], 15, 0);
            total++;
            if (bus.disp_hour !== 6'(disp[i]) || bus.pm !== pmv[i] ||
                obs_vec() !== exp_vec())
                $display("FAIL mode12 h%0d got disp=%0d pm=%b want disp=%0d pm=%b",
                         hrs[i], bus.disp_hour, bus.pm, disp[i], pmv[i]);
            else passed++;
        end
        bus.mode12 = 1'b0;
        bus.run    = 1'b1;
        set_time(13, 45, 30);
        cyc();
        cyc();
        cyc();
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        total++;
        if (obs_vec() !== 29'd0 || obs_vec() !== exp_vec())
            $display("FAIL midrun_reset got %h want 0", obs_vec());
        else passed++;
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        total++;
        if (bus.sec !== 6'd1 || bus.sec_tick !== 1'b1)
            $display("FAIL post_reset_phase got sec=%0d tick=%b want sec=1 tick=1",
                     bus.sec, bus.sec_tick);
        else passed++;
    endtask

    task automatic test_random();
        bus.alarm_en   = 1'b1;
        for (int i = 0; i < 400; i++) begin
            bus.run    = ($urandom_range(0, 3) != 0);
            bus.load   = ($urandom_range(0, 9) == 0);
            bus.mode12 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                bus.set_hour = 6'($urandom_range(0, 63));
                bus.set_min  = 6'($urandom_range(0, 63));
                bus.set_sec  = 6'($urandom_range(0, 63));
            end else begin
                bus.set_hour = 6'($urandom_range(0, 23));
                bus.set_min  = 6'($urandom_range(57, 59));
                bus.set_sec  = 6'($urandom_range(55, 59));
            end
            if ($urandom_range(0, 15) == 0) begin
                bus.alarm_hour = 6'($urandom_range(0, 25));
                bus.alarm_min  = 6'($urandom_range(0, 61));
            end
            cyc();
            total++;
            if (obs_vec() !== exp_vec())
                $display("FAIL random c%0d got %h want %h", i, obs_vec(), exp_vec());
            else passed++;
        end
        bus.load     = 1'b0;
        bus.alarm_en = 1'b0;
        bus.mode12   = 1'b0;
    endtask

    initial begin
        bus.run        = 1'b0;
        bus.load       = 1'b0;
        bus.set_hour   = 6'd0;
        bus.set_min    = 6'd0;
        bus.set_sec    = 6'd0;
        bus.alarm_en   = 1'b0;
        bus.alarm_hour = 6'd0;
        bus.alarm_min  = 6'd0;
        bus.mode12     = 1'b0;
        model_reset();
        test_reset();
        test_first_second();
        test_day_rollover();
        test_load_err();
        test_alarm();
        test_hold();
        test_mode12();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
